// File: rtl/line_setup_pkg.sv
// line_setup_pkg: shared constants and the setup-result record for the line engine.
// The line-drawing FSM consumes line_setup_t; line_setup uses the defaults below.
package line_setup_pkg;

  // Default geometry of the line engine datapath.
  localparam int LS_COORD_W    = 10;
  localparam int LS_FRAME_W    = 32;
  localparam int LS_FB_SEL_LSB = 22;
  localparam int LS_FB_SEL_W   = 3;

  // Bresenham setup values handed to the line-drawing FSM.
  typedef struct packed {
    logic [LS_COORD_W:0]    abs_dx;
    logic [LS_COORD_W:0]    abs_dy;
    logic                   step_x;
    logic                   step_y;
    logic                   steep;
    logic [LS_COORD_W:0]    err_init;
    logic [LS_COORD_W+1:0]  length;
    logic [LS_FB_SEL_W-1:0] fb_sel;
  } line_setup_t;

  // Pixel count of a line whose major-axis delta is 'major'.
  function automatic logic [LS_COORD_W+1:0] pixel_count(input logic [LS_COORD_W:0] major);
    return {1'b0, major} + {{(LS_COORD_W+1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/line_setup_abs.sv
// abs_diff: sign-extended difference b - a and its magnitude.
// The difference is one bit wider than the operands, so it never wraps.
module abs_diff
  import line_setup_pkg::*;
#(
  parameter int W = LS_COORD_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic        [W:0]   mag,
  output logic                neg
);

  logic [W:0] diff;

  // Subtract in W+1 bits, then fold negative results into a magnitude.
  always_comb begin
    diff = {b[W-1], b} - {a[W-1], a};
    neg  = diff[W];
    mag  = neg ? (~diff + {{W{1'b0}}, 1'b1}) : diff;
  end

endmodule

// File: rtl/line_setup.sv
// line_setup: two-stage pipelined Bresenham setup for the line engine.
// Stage 1 forms the absolute deltas and step directions; stage 2 picks the
// major axis and produces steep, initial error and pixel count.
// Optional feature: define LINE_SETUP_FB_SEL_EN to carry the frame-buffer
// select field of Frame through the pipe; otherwise FbSel reads 0.
module line_setup
  import line_setup_pkg::*;
#(
  parameter int COORD_W    = LS_COORD_W,
  parameter int FRAME_W    = LS_FRAME_W,
  parameter int FB_SEL_LSB = LS_FB_SEL_LSB,
  parameter int FB_SEL_W   = LS_FB_SEL_W
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic signed [COORD_W-1:0] X0,
  input  logic signed [COORD_W-1:0] Y0,
  input  logic signed [COORD_W-1:0] X1,
  input  logic signed [COORD_W-1:0] Y1,
  input  logic        [FRAME_W-1:0] Frame,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic        [COORD_W:0]   AbsDx,
  output logic        [COORD_W:0]   AbsDy,
  output logic                      StepX,
  output logic                      StepY,
  output logic                      Steep,
  output logic        [COORD_W:0]   ErrInit,
  output logic        [COORD_W+1:0] Length,
  output logic       [FB_SEL_W-1:0] FbSel
);

  // Pipeline occupancy and load enables
  logic v1;
  logic v2;
  logic s1_load;
  logic s2_load;

  // Stage 1 combinational deltas
  logic [COORD_W:0] dx_mag;
  logic [COORD_W:0] dy_mag;
  logic             dx_neg;
  logic             dy_neg;

  // Stage 1 registers
  logic [COORD_W:0] s1_abs_dx;
  logic [COORD_W:0] s1_abs_dy;
  logic             s1_step_x;
  logic             s1_step_y;

  // Stage 2 combinational setup values
  logic               steep_c;
  logic [COORD_W:0]   major_c;
  logic [COORD_W:0]   err_c;
  logic [COORD_W+1:0] len_c;

  // Stage 2 (output) registers
  logic [COORD_W:0]   s2_abs_dx;
  logic [COORD_W:0]   s2_abs_dy;
  logic               s2_step_x;
  logic               s2_step_y;
  logic               s2_steep;
  logic [COORD_W:0]   s2_err;
  logic [COORD_W+1:0] s2_len;

  // Frame select field aligned to bit 0; bits above the field are don't-care.
  logic [FRAME_W-1:0] frame_shift;
  logic               unused_frame;

  assign frame_shift  = Frame >> FB_SEL_LSB;
  assign unused_frame = ^frame_shift;

  // A stage loads when it is empty or its contents leave on the same edge.
  assign s2_load = !v2 || OutReady;
  assign s1_load = !v1 || s2_load;
  assign InReady = s1_load;

  abs_diff #(.W(COORD_W)) u_abs_x (
    .a   (X0),
    .b   (X1),
    .mag (dx_mag),
    .neg (dx_neg)
  );

  abs_diff #(.W(COORD_W)) u_abs_y (
    .a   (Y0),
    .b   (Y1),
    .mag (dy_mag),
    .neg (dy_neg)
  );

  // Stage 1: capture deltas and directions of an accepted transaction.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      v1        <= 1'b0;
      s1_abs_dx <= '0;
      s1_abs_dy <= '0;
      s1_step_x <= 1'b0;
      s1_step_y <= 1'b0;
    end else if (s1_load) begin
      v1 <= InValid;
      if (InValid) begin
        s1_abs_dx <= dx_mag;
        s1_abs_dy <= dy_mag;
        s1_step_x <= dx_neg;
        s1_step_y <= dy_neg;
      end
    end
  end

  // Major axis selection; ties resolve to the x axis (not steep).
  always_comb begin
    steep_c = s1_abs_dy > s1_abs_dx;
    major_c = steep_c ? s1_abs_dy : s1_abs_dx;
    err_c   = major_c >> 1;
    len_c   = {1'b0, major_c} + {{(COORD_W+1){1'b0}}, 1'b1};
  end

  // Stage 2: register the full setup result; holds while the consumer stalls.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      v2        <= 1'b0;
      s2_abs_dx <= '0;
      s2_abs_dy <= '0;
      s2_step_x <= 1'b0;
      s2_step_y <= 1'b0;
      s2_steep  <= 1'b0;
      s2_err    <= '0;
      s2_len    <= '0;
    end else if (s2_load) begin
      v2 <= v1;
      if (v1) begin
        s2_abs_dx <= s1_abs_dx;
        s2_abs_dy <= s1_abs_dy;
        s2_step_x <= s1_step_x;
        s2_step_y <= s1_step_y;
        s2_steep  <= steep_c;
        s2_err    <= err_c;
        s2_len    <= len_c;
      end
    end
  end

`ifdef LINE_SETUP_FB_SEL_EN
  logic [FB_SEL_W-1:0] s1_fb_sel;
  logic [FB_SEL_W-1:0] s2_fb_sel;

  // Frame select travels alongside the data through both stages.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_fb_sel <= '0;
      s2_fb_sel <= '0;
    end else begin
      if (s1_load && InValid) begin
        s1_fb_sel <= frame_shift[FB_SEL_W-1:0];
      end
      if (s2_load && v1) begin
        s2_fb_sel <= s1_fb_sel;
      end
    end
  end

  assign FbSel = s2_fb_sel;
`else
  assign FbSel = '0;
`endif

  assign OutValid = v2;
  assign AbsDx    = s2_abs_dx;
  assign AbsDy    = s2_abs_dy;
  assign StepX    = s2_step_x;
  assign StepY    = s2_step_y;
  assign Steep    = s2_steep;
  assign ErrInit  = s2_err;
  assign Length   = s2_len;

endmodule

// File: tb/tb_line_setup.sv
// tb_line_setup: directed, table-driven bench for line_setup.
// Expected FbSel follows LINE_SETUP_FB_SEL_EN (field value when defined, else 0).
module tb_line_setup;

  localparam int NV = 7;

  logic               Clock;
  logic               Reset;
  logic               InValid;
  logic               InReady;
  logic signed [9:0]  X0, Y0, X1, Y1;
  logic [31:0]        Frame;
  logic               OutValid;
  logic               OutReady;
  logic [10:0]        AbsDx, AbsDy;
  logic               StepX, StepY, Steep;
  logic [10:0]        ErrInit;
  logic [11:0]        Length;
  logic [2:0]         FbSel;

  int checks;
  int passes;

  typedef struct {
    logic signed [9:0] x0, y0, x1, y1;
    logic [31:0]       frame;
    int                dx, dy, sx, sy, steep, err, len, fb;
  } vec_t;

  vec_t vec [NV];

  line_setup dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .X0       (X0),
    .Y0       (Y0),
    .X1       (X1),
    .Y1       (Y1),
    .Frame    (Frame),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .AbsDx    (AbsDx),
    .AbsDy    (AbsDy),
    .StepX    (StepX),
    .StepY    (StepY),
    .Steep    (Steep),
    .ErrInit  (ErrInit),
    .Length   (Length),
    .FbSel    (FbSel)
  );

  // 100 MHz free-running clock
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic vec_t mk(input int x0, input int y0, input int x1, input int y1,
                              input logic [31:0] frame, input int dx, input int dy,
                              input int sx, input int sy, input int steep,
                              input int err, input int len, input int fb);
    vec_t v;
    v.x0 = 10'(x0); v.y0 = 10'(y0); v.x1 = 10'(x1); v.y1 = 10'(y1);
    v.frame = frame;
    v.dx = dx; v.dy = dy; v.sx = sx; v.sy = sy; v.steep = steep;
    v.err = err; v.len = len; v.fb = fb;
    return v;
  endfunction

  function automatic int expFb(input int raw);
`ifdef LINE_SETUP_FB_SEL_EN
    return raw;
`else
    return 0 * raw;
`endif
  endfunction

  task automatic checkField(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkOutput(input int idx, input string tag);
    checkField({tag, "_valid"}, int'(OutValid), 1);
    checkField({tag, "_absdx"}, int'(AbsDx), vec[idx].dx);
    checkField({tag, "_absdy"}, int'(AbsDy), vec[idx].dy);
    checkField({tag, "_stepx"}, int'(StepX), vec[idx].sx);
    checkField({tag, "_stepy"}, int'(StepY), vec[idx].sy);
    checkField({tag, "_steep"}, int'(Steep), vec[idx].steep);
    checkField({tag, "_errinit"}, int'(ErrInit), vec[idx].err);
    checkField({tag, "_length"}, int'(Length), vec[idx].len);
    checkField({tag, "_fbsel"}, int'(FbSel), expFb(vec[idx].fb));
  endtask

  task automatic driveInputs(input int idx);
    X0 = vec[idx].x0; Y0 = vec[idx].y0;
    X1 = vec[idx].x1; Y1 = vec[idx].y1;
    Frame = vec[idx].frame;
    InValid = 1'b1;
  endtask

  // Offer one transaction and return just after the edge that accepts it.
  task automatic applyStimulus(input int idx);
    int guard;
    driveInputs(idx);
    guard = 0;
    while (!InReady && guard < 20) begin
      @(posedge Clock); #1;
      guard++;
    end
    checkField("accept_ready", int'(InReady), 1);
    @(posedge Clock); #1;
    InValid = 1'b0;
  endtask

  initial begin
    int k;
    checks = 0;
    passes = 0;
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    X0 = '0; Y0 = '0; X1 = '0; Y1 = '0; Frame = '0;

    //        x0    y0    x1   y1   frame          dx    dy  sx sy st err  len  fb
    vec[0] = mk(40,   10,   10,  20, 32'h1080_0000, 30,   10, 1, 0, 0, 15,  31,  2);
    vec[1] = mk(-512, 0,    511, 0,  32'h0000_0000, 1023, 0,  0, 0, 0, 511, 1024, 0);
    vec[2] = mk(511,  0,   -512, 0,  32'hFE3F_FFFF, 1023, 0,  1, 0, 0, 511, 1024, 0);
    vec[3] = mk(0,    0,    3,  -7,  32'h0040_0000, 3,    7,  0, 1, 1, 3,   8,   1);
    vec[4] = mk(0,    0,    5,   5,  32'h0100_0000, 5,    5,  0, 0, 0, 2,   6,   4);
    vec[5] = mk(7,    7,    7,   7,  32'h0180_0000, 0,    0,  0, 0, 0, 0,   1,   6);
    vec[6] = mk(0,   -512,  0,  511, 32'h01C0_0000, 0,    1023, 0, 0, 1, 511, 1024, 7);

    // Reset state
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    checkField("rst_outvalid", int'(OutValid), 0);
    checkField("rst_inready", int'(InReady), 1);
    checkField("rst_absdx", int'(AbsDx), 0);
    checkField("rst_length", int'(Length), 0);
    checkField("rst_fbsel", int'(FbSel), 0);

    // One transaction at a time: exact 2-cycle latency and all fields
    OutReady = 1'b1;
    for (int i = 0; i < NV; i++) begin
      applyStimulus(i);
      checkField("lat_early", int'(OutValid), 0);
      @(posedge Clock); #1;
      checkOutput(i, "single");
      @(posedge Clock); #1;
    end

    // Back-to-back stream with OutReady high: one result per cycle, in order
    k = 0;
    for (int c = 0; c < NV + 4; c++) begin
      if (c < NV) begin
        driveInputs(c);
        checkField("stream_inready", int'(InReady), 1);
      end else begin
        InValid = 1'b0;
      end
      @(posedge Clock); #1;
      if (OutValid) begin
        if (k < NV) checkOutput(k, "stream");
        k++;
      end
    end
    checkField("stream_count", k, NV);
    checkField("stream_first_cycle_gap", int'(OutValid), 0);

    // Backpressure: three offers with OutReady low
    OutReady = 1'b0;
    driveInputs(0);
    checkField("bp_ready1", int'(InReady), 1);
    @(posedge Clock); #1;
    driveInputs(3);
    checkField("bp_ready2", int'(InReady), 1);
    @(posedge Clock); #1;
    driveInputs(4);
    checkField("bp_ready3_low", int'(InReady), 0);
    checkOutput(0, "bp_hold0");
    @(posedge Clock); #1;
    checkField("bp_still_low", int'(InReady), 0);
    checkOutput(0, "bp_hold1");
    @(posedge Clock); #1;
    checkOutput(0, "bp_hold2");
    OutReady = 1'b1;
    #1;
    checkField("bp_ready_comb", int'(InReady), 1);
    @(posedge Clock); #1;
    InValid = 1'b0;
    checkOutput(3, "bp_out2");
    @(posedge Clock); #1;
    checkOutput(4, "bp_out3");
    @(posedge Clock); #1;
    checkField("bp_drained", int'(OutValid), 0);

    // Reset mid-flight with both stages full
    OutReady = 1'b0;
    driveInputs(1);
    @(posedge Clock); #1;
    driveInputs(2);
    @(posedge Clock); #1;
    InValid = 1'b0;
    checkField("mid_full", int'(InReady), 0);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    checkField("mid_outvalid", int'(OutValid), 0);
    checkField("mid_inready", int'(InReady), 1);
    checkField("mid_absdx", int'(AbsDx), 0);
    OutReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge Clock); #1;
      checkField("mid_no_stale", int'(OutValid), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
